pong_plotter: RTL
=================

# pong_plotter

Pixel-write sequencer between the Pong game logic and `vga_adapter`. On each `start` pulse it latches the current left paddle, right paddle and ball positions. It then streams one pixel per cycle through the adapter's `x`/`y`/`colour`/`plot` port: optionally erasing each object at its previous position, then drawing it at its new one. It is the single owner of the adapter write port and reports which object is being drawn on `draw_state`.

## Interface
Parameters:
- `PADDLE_W`, 4: paddle width in pixels.
- `PADDLE_H`, 10: paddle height in pixels (40 pixels per paddle).
- `BALL_S`, 4: ball side length in pixels (16 pixels).
- `L_X`, 8: left paddle fixed x.
- `R_X`, 148: right paddle fixed x.
- `PADDLE_COLOUR`, 3'b111: paddle draw colour.
- `BALL_COLOUR`, 3'b111: ball draw colour.

Ports:
- `clk`, in, 1: the one clock.
- `reset`, in, 1: synchronous, active-high.
- `start`, in, 1: frame request; sampled only in IDLE.
- `l_paddle_y`, in, 7: left paddle top row.
- `r_paddle_y`, in, 7: right paddle top row.
- `ball_x`, in, 8: ball left column.
- `ball_y`, in, 7: ball top row.
- `x`, out, 8: pixel column to the adapter.
- `y`, out, 7: pixel row to the adapter.
- `colour`, out, 3: pixel colour to the adapter.
- `plot`, out, 1: adapter write enable.
- `draw_state`, out, 2: object in progress. 00 none, 01 left paddle, 11 right paddle, 10 ball.
- `busy`, out, 1: high in every state except IDLE.
- `done`, out, 1: one-cycle pulse at frame end.

## Operation
- States and transitions:
  - IDLE → LOAD when `start`=1. `start` is ignored in all other states.
  - LOAD (1 cycle) → ERASE_L.
  - ERASE_L → DRAW_L → ERASE_R → DRAW_R → ERASE_B → DRAW_B → DONE.
  - DONE (1 cycle) → IDLE.
- LOAD actions:
  - Copies the current positions into the `prev_*` registers.
  - Latches the `start`-time input positions into the `cur_*` registers.
  - Clears the pixel counters.
  - Input changes after LOAD have no effect on the frame.
- Pixel counters `cx`, `cy` scan row-major:
  - `cx` increments every cycle and wraps at width−1.
  - `cy` increments on each `cx` wrap.
  - The state advances on the cycle where `cx`=W−1 and `cy`=H−1; both counters clear on that advance.
- Pixel coordinates:
  - `x` = base_x + `cx`; `y` = base_y + `cy`. Sums are computed one bit wider than the output.
  - Base is the `prev_*` set in ERASE states and the `cur_*` set in DRAW states.
  - Paddle base_x is `L_X` or `R_X`.
- `colour`:
  - 3'b000 in ERASE states.
  - `PADDLE_COLOUR` in DRAW_L and DRAW_R.
  - `BALL_COLOUR` in DRAW_B.
- Clipping:
  - `plot` = 1 in ERASE/DRAW states only when the wide sum satisfies x ≤ 159 and y ≤ 119.
  - Clipped pixels still consume their cycle.
  - `x`/`y` carry the truncated sum.
- `draw_state`:
  - 01 in ERASE_L and DRAW_L; 11 in ERASE_R and DRAW_R; 10 in ERASE_B and DRAW_B.
  - 00 otherwise.
- All outputs are Moore, decoded from the state and counter registers.

## Timing
- Reset: state IDLE, `prev_*` and `cur_*` = 0, counters = 0.
- Reset output values: `plot`=0, `busy`=0, `done`=0, `draw_state`=00, `x`=0, `y`=0, `colour`=0.
- Reset mid-frame: the next cycle is IDLE with all of the above. The frame is abandoned and no `done` is issued.
- With `start` sampled high at edge 0:
  - Cycle 1 is LOAD.
  - The first `plot` is in cycle 2, at (L_X, prev_l_y).
- Frame lengths with erase: ERASE_L/DRAW_L 40 cycles each, ERASE_R/DRAW_R 40 each, ERASE_B/DRAW_B 16 each. `done` is in cycle 194 and IDLE in cycle 195.
- `start` held high continuously: a new frame begins with LOAD in the cycle after IDLE.
- Throughput: at most one pixel per cycle; no back-pressure from the adapter.

## Configuration
- `PONG_PLOTTER_ERASE_EN` defined:
  - ERASE states exist as described.
  - The first frame after reset erases at positions (L_X,0), (R_X,0) and (0,0).
- Not defined:
  - ERASE states and `prev_*` registers are omitted; LOAD → DRAW_L directly.
  - First `plot` in cycle 2 at (L_X, cur_l_y); `done` in cycle 98.

## Test plan
- Reset then a single `start` (erase on) with l_paddle_y=20, r_paddle_y=50, ball=(80,60):
  - 192 `plot` cycles.
  - DRAW_L covers x 8..11, y 20..29 in row-major order with colour 111.
  - `done` in cycle 194.
- Second frame with l_paddle_y=30:
  - ERASE_L writes colour 000 over x 8..11, y 20..29.
  - DRAW_L then writes x 8..11, y 30..39.
- Clipping with ball=(158,118):
  - DRAW_B still lasts 16 cycles.
  - `plot` is high only for (158..159, 118..119): 4 pixels.
- `start` pulsed during DRAW_R:
  - Ignored; exactly one `done`.
  - `busy` falls in the cycle after `done`.
- `reset` asserted in cycle 60:
  - Cycle 61 shows `plot`=0, `busy`=0, `draw_state`=00.
  - No `done` pulse.
- Macro undefined, same stimulus as the first test:
  - 96 `plot` cycles; `done` in cycle 98.
  - `draw_state` sequence is 01 (40), 11 (40), 10 (16).

Source files
------------

// File: rtl/pong_plotter.sv
// pong_plotter
//
// Pixel-write sequencer sitting between the Pong game logic and vga_adapter.
// A start pulse in IDLE captures the paddle and ball positions. The block then
// streams one pixel per cycle to the adapter: each object is optionally erased
// at its previous position and then drawn at its new one. Order: left paddle,
// right paddle, ball.
//
// Build option:
//   PONG_PLOTTER_ERASE_EN - when defined, ERASE_L/ERASE_R/ERASE_B states and the
//                           prev_* position registers exist. When undefined,
//                           LOAD goes straight to DRAW_L.
//
// Ports:
//   clk         in   1  clock
//   reset       in   1  synchronous, active-high reset
//   start       in   1  frame request, sampled only in IDLE
//   l_paddle_y  in   7  left paddle top row
//   r_paddle_y  in   7  right paddle top row
//   ball_x      in   8  ball left column
//   ball_y      in   7  ball top row
//   x           out  8  pixel column to the adapter
//   y           out  7  pixel row to the adapter
//   colour      out  3  pixel colour to the adapter
//   plot        out  1  adapter write enable
//   draw_state  out  2  00 none, 01 left paddle, 11 right paddle, 10 ball
//   busy        out  1  high in every state except IDLE
//   done        out  1  one-cycle pulse in the DONE state
module pong_plotter #(
  parameter int         PADDLE_W      = 4,
  parameter int         PADDLE_H      = 10,
  parameter int         BALL_S        = 4,
  parameter int         L_X           = 8,
  parameter int         R_X           = 148,
  parameter logic [2:0] PADDLE_COLOUR = 3'b111,
  parameter logic [2:0] BALL_COLOUR   = 3'b111
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [6:0] l_paddle_y,
  input  logic [6:0] r_paddle_y,
  input  logic [7:0] ball_x,
  input  logic [6:0] ball_y,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic [1:0] draw_state,
  output logic       busy,
  output logic       done
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
`ifdef PONG_PLOTTER_ERASE_EN
    S_ERASE_L,
    S_ERASE_R,
    S_ERASE_B,
`endif
    S_DRAW_L,
    S_DRAW_R,
    S_DRAW_B,
    S_DONE
  } state_t;

  localparam logic [7:0] PW8 = 8'(PADDLE_W);
  localparam logic [6:0] PH7 = 7'(PADDLE_H);
  localparam logic [7:0] BS8 = 8'(BALL_S);
  localparam logic [6:0] BS7 = 7'(BALL_S);
  localparam logic [7:0] LX8 = 8'(L_X);
  localparam logic [7:0] RX8 = 8'(R_X);

  localparam logic [1:0] DS_NONE = 2'b00;
  localparam logic [1:0] DS_L    = 2'b01;
  localparam logic [1:0] DS_R    = 2'b11;
  localparam logic [1:0] DS_B    = 2'b10;

  state_t     state_reg, state_next;
  logic [7:0] cx_reg, cx_next;
  logic [6:0] cy_reg, cy_next;

  logic [6:0] cur_l_y_reg, cur_r_y_reg, cur_ball_y_reg;
  logic [7:0] cur_ball_x_reg;
`ifdef PONG_PLOTTER_ERASE_EN
  logic [6:0] prev_l_y_reg, prev_r_y_reg, prev_ball_y_reg;
  logic [7:0] prev_ball_x_reg;
`endif

  // Per-state decode of the object being scanned.
  logic       active;
  logic [7:0] obj_w;
  logic [6:0] obj_h;
  logic [7:0] base_x;
  logic [6:0] base_y;
  logic [2:0] obj_colour;
  logic [1:0] obj_ds;
  state_t     after_obj;
  logic       last_pix;
  // One bit wider than the outputs so off-screen pixels can be detected.
  logic [8:0] sum_x;
  logic [7:0] sum_y;

  always_comb begin
    active     = 1'b0;
    obj_w      = 8'd0;
    obj_h      = 7'd0;
    base_x     = 8'd0;
    base_y     = 7'd0;
    obj_colour = 3'b000;
    obj_ds     = DS_NONE;
    after_obj  = S_IDLE;
    state_next = state_reg;

    case (state_reg)
      S_IDLE: begin
        if (start) state_next = S_LOAD;
      end
      S_LOAD: begin
`ifdef PONG_PLOTTER_ERASE_EN
        state_next = S_ERASE_L;
`else
        state_next = S_DRAW_L;
`endif
      end
`ifdef PONG_PLOTTER_ERASE_EN
      S_ERASE_L: begin
        active    = 1'b1;
        obj_w     = PW8;
        obj_h     = PH7;
        base_x    = LX8;
        base_y    = prev_l_y_reg;
        obj_ds    = DS_L;
        after_obj = S_DRAW_L;
      end
      S_ERASE_R: begin
        active    = 1'b1;
        obj_w     = PW8;
        obj_h     = PH7;
        base_x    = RX8;
        base_y    = prev_r_y_reg;
        obj_ds    = DS_R;
        after_obj = S_DRAW_R;
      end
      S_ERASE_B: begin
        active    = 1'b1;
        obj_w     = BS8;
        obj_h     = BS7;
        base_x    = prev_ball_x_reg;
        base_y    = prev_ball_y_reg;
        obj_ds    = DS_B;
        after_obj = S_DRAW_B;
      end
`endif
      S_DRAW_L: begin
        active     = 1'b1;
        obj_w      = PW8;
        obj_h      = PH7;
        base_x     = LX8;
        base_y     = cur_l_y_reg;
        obj_colour = PADDLE_COLOUR;
        obj_ds     = DS_L;
`ifdef PONG_PLOTTER_ERASE_EN
        after_obj  = S_ERASE_R;
`else
        after_obj  = S_DRAW_R;
`endif
      end
      S_DRAW_R: begin
        active     = 1'b1;
        obj_w      = PW8;
        obj_h      = PH7;
        base_x     = RX8;
        base_y     = cur_r_y_reg;
        obj_colour = PADDLE_COLOUR;
        obj_ds     = DS_R;
`ifdef PONG_PLOTTER_ERASE_EN
        after_obj  = S_ERASE_B;
`else
        after_obj  = S_DRAW_B;
`endif
      end
      S_DRAW_B: begin
        active     = 1'b1;
        obj_w      = BS8;
        obj_h      = BS7;
        base_x     = cur_ball_x_reg;
        base_y     = cur_ball_y_reg;
        obj_colour = BALL_COLOUR;
        obj_ds     = DS_B;
        after_obj  = S_DONE;
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase

    last_pix = active && (cx_reg == obj_w - 8'd1) && (cy_reg == obj_h - 7'd1);
    if (last_pix) state_next = after_obj;

    // Row-major scan; clipped pixels still take their cycle.
    cx_next = cx_reg;
    cy_next = cy_reg;
    if (state_reg == S_LOAD) begin
      cx_next = 8'd0;
      cy_next = 7'd0;
    end else if (active) begin
      if (cx_reg == obj_w - 8'd1) begin
        cx_next = 8'd0;
        cy_next = (cy_reg == obj_h - 7'd1) ? 7'd0 : cy_reg + 7'd1;
      end else begin
        cx_next = cx_reg + 8'd1;
      end
    end

    sum_x = {1'b0, base_x} + {1'b0, cx_reg};
    sum_y = {1'b0, base_y} + {1'b0, cy_reg};

    x          = active ? sum_x[7:0] : 8'd0;
    y          = active ? sum_y[6:0] : 7'd0;
    colour     = obj_colour;
    plot       = active && (sum_x <= 9'd159) && (sum_y <= 8'd119);
    draw_state = obj_ds;
    busy       = (state_reg != S_IDLE);
    done       = (state_reg == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= S_IDLE;
      cx_reg         <= 8'd0;
      cy_reg         <= 7'd0;
      cur_l_y_reg    <= 7'd0;
      cur_r_y_reg    <= 7'd0;
      cur_ball_x_reg <= 8'd0;
      cur_ball_y_reg <= 7'd0;
`ifdef PONG_PLOTTER_ERASE_EN
      prev_l_y_reg    <= 7'd0;
      prev_r_y_reg    <= 7'd0;
      prev_ball_x_reg <= 8'd0;
      prev_ball_y_reg <= 7'd0;
`endif
    end else begin
      state_reg <= state_next;
      cx_reg    <= cx_next;
      cy_reg    <= cy_next;
      // Positions are captured on the edge that enters LOAD, so the frame
      // uses exactly the values present when start was accepted.
      if (state_reg == S_IDLE && start) begin
`ifdef PONG_PLOTTER_ERASE_EN
        prev_l_y_reg    <= cur_l_y_reg;
        prev_r_y_reg    <= cur_r_y_reg;
        prev_ball_x_reg <= cur_ball_x_reg;
        prev_ball_y_reg <= cur_ball_y_reg;
`endif
        cur_l_y_reg    <= l_paddle_y;
        cur_r_y_reg    <= r_paddle_y;
        cur_ball_x_reg <= ball_x;
        cur_ball_y_reg <= ball_y;
      end
    end
  end

endmodule
